// File: rtl/uart_tx_sched.sv
// Two-requester round-robin transmit scheduler for the memory-mapped UART (TX 0xFF00, STATUS 0xFF02).
// Optional line lock enabled by defining UART_SCHED_LINE_LOCK_EN.
module uart_tx_sched (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req0_valid,
    input  logic [7:0]  req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [7:0]  req1_data,
    output logic        req1_ready,
    output logic [15:0] uart_addr,
    output logic [7:0]  uart_wdata,
    input  logic [7:0]  uart_rdata,
    output logic        uart_rd,
    output logic        uart_wr,
    output logic        busy,
    output logic        grant
);

    localparam logic [15:0] ADDR_TX     = 16'hFF00;
    localparam logic [15:0] ADDR_STATUS = 16'hFF02;

    typedef enum logic [1:0] {IDLE, LATCH, POLL, WRITE} state_e;

    state_e     state_q, state_d;
    logic       grant_q, grant_d;
    logic       lastGrant_q, lastGrant_d;
    logic [7:0] txByte_q, txByte_d;
    logic       elig0, elig1;

    // Only STATUS bit0 (tx idle) matters to the scheduler.
    logic unusedRdata;
    assign unusedRdata = ^uart_rdata[7:1];

`ifdef UART_SCHED_LINE_LOCK_EN
    parameter logic [7:0]  LINE_END     = 8'h0A;
    parameter int unsigned LOCK_TIMEOUT = 1024;
    localparam int CW = $clog2(LOCK_TIMEOUT) + 1;

    logic          lockValid_q, lockValid_d;
    logic          lockId_q, lockId_d;
    logic [CW-1:0] lockCnt_q, lockCnt_d;
    logic          holderValid;

    assign holderValid = lockId_q ? req1_valid : req0_valid;
    assign elig0 = req0_valid && (!lockValid_q || !lockId_q);
    assign elig1 = req1_valid && (!lockValid_q ||  lockId_q);

    // The idle counter only runs while the holder has nothing to send; anything else restarts it.
    always_comb begin
        lockValid_d = lockValid_q;
        lockId_d    = lockId_q;
        lockCnt_d   = '0;
        if (state_q == WRITE) begin
            if (txByte_q == LINE_END) begin
                lockValid_d = 1'b0;
            end else begin
                lockValid_d = 1'b1;
                lockId_d    = grant_q;
            end
        end else if (state_q == IDLE && lockValid_q && !holderValid) begin
            if (lockCnt_q == CW'(LOCK_TIMEOUT - 1)) begin
                lockValid_d = 1'b0;
            end else begin
                lockCnt_d = lockCnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lockValid_q <= 1'b0;
            lockId_q    <= 1'b0;
            lockCnt_q   <= '0;
        end else begin
            lockValid_q <= lockValid_d;
            lockId_q    <= lockId_d;
            lockCnt_q   <= lockCnt_d;
        end
    end
`else
    assign elig0 = req0_valid;
    assign elig1 = req1_valid;
`endif

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        lastGrant_d = lastGrant_q;
        txByte_d    = txByte_q;
        unique case (state_q)
            IDLE: begin
                if (elig0 && elig1) begin
                    grant_d = ~lastGrant_q;
                    state_d = LATCH;
                end else if (elig0 || elig1) begin
                    grant_d = elig1;
                    state_d = LATCH;
                end
            end
            LATCH: begin
                txByte_d = grant_q ? req1_data : req0_data;
                state_d  = POLL;
            end
            POLL: begin
                if (uart_rdata[0]) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                lastGrant_d = grant_q;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // lastGrant resets to 1 so requester 0 wins the very first tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            grant_q     <= 1'b0;
            lastGrant_q <= 1'b1;
            txByte_q    <= 8'h00;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            lastGrant_q <= lastGrant_d;
            txByte_q    <= txByte_d;
        end
    end

    always_comb begin
        uart_addr  = 16'h0000;
        uart_wdata = 8'h00;
        uart_rd    = 1'b0;
        uart_wr    = 1'b0;
        if (state_q == POLL) begin
            uart_addr = ADDR_STATUS;
            uart_rd   = 1'b1;
        end else if (state_q == WRITE) begin
            uart_addr  = ADDR_TX;
            uart_wdata = txByte_q;
            uart_wr    = 1'b1;
        end
    end

    assign req0_ready = (state_q == LATCH) && !grant_q;
    assign req1_ready = (state_q == LATCH) &&  grant_q;
    assign busy       = (state_q != IDLE);
    assign grant      = grant_q;

endmodule
